mem_dump: RTL and testbench
===========================

Name: mem_dump

Overview:
- Reads back the CPU's word memory and streams it out as bytes, the reverse of program loading.
- On `start`, holds the CPU, walks addresses 0 to MEMORY_SIZE-1, and emits each 16-bit word as two bytes (high byte first) on a valid/ready byte stream.
- Sits beside `cpu`, sharing its memory read port.
- Feeds a byte sink (UART transmitter or bench monitor) so memory contents can be compared against the assembler binary.

Parameters:
- MEMORY_SIZE, 32, number of 16-bit words to dump; must equal the `cpu` MEMORY_SIZE.
- ADDR_W, $clog2(MEMORY_SIZE), width of the memory address bus; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- cpu_hold  output  1  high while a dump is in progress; the CPU stalls and releases its memory port.
- mem_rd_en  output  1  read strobe to memory.
- mem_addr  output  ADDR_W  word address being read.
- mem_rdata  input  16  read data, valid exactly 1 cycle after mem_rd_en.
- tx_data  output  8  outgoing byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte when tx_valid && tx_ready on a rising clk edge.
- busy  output  1  dump in progress (state != IDLE).
- done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, addr=0, cpu_hold=0, mem_rd_en=0, mem_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, word buffer=0.
- Reset asserted mid-dump aborts immediately:
  - tx_valid and cpu_hold drop without waiting for a handshake.
  - No done pulse is produced.
- States: IDLE, HOLD, READ, WAIT, SEND_HI, SEND_LO, FINISH.
- IDLE: start=1 -> HOLD, addr=0, cpu_hold=1. start while not IDLE is ignored.
- HOLD: one cycle so the CPU can release memory. -> READ.
- READ: mem_rd_en=1, mem_addr=addr. -> WAIT.
- WAIT: capture mem_rdata into the word buffer. -> SEND_HI.
- SEND_HI: tx_valid=1, tx_data=buf[15:8]. On handshake -> SEND_LO.
- SEND_LO: tx_valid=1, tx_data=buf[7:0]. On handshake:
  - if addr==MEMORY_SIZE-1 -> FINISH;
  - else addr<=addr+1 and -> READ.
- FINISH: done=1 for one cycle, cpu_hold=0 -> IDLE.
- mem_rd_en is high only in READ. mem_addr holds its last value otherwise.
- Stream rules:
  - tx_data is stable, and tx_valid never drops, until the handshake.
  - tx_valid never depends combinationally on tx_ready.
  - tx_ready high outside SEND_* has no effect.
- Throughput with tx_ready tied high: 4 cycles per word (READ, WAIT, SEND_HI, SEND_LO).
- Total from start to done, with tx_ready high: 1 + 4*MEMORY_SIZE + 1 cycles.
- Back-pressure of any length is tolerated with no byte loss or duplication.
- addr never exceeds MEMORY_SIZE-1; there is no wrap-around and no read past the end.
- MEMORY_SIZE=1: dumps a single word, then FINISH.
- start coincident with done: ignored, because done occurs in FINISH, not IDLE.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of every emitted data byte is kept; it is cleared on the IDLE->HOLD transition.
  - After the last SEND_LO handshake, an extra state SEND_CK emits the two's-complement negation of that sum, so all bytes plus the checksum byte sum to 0 mod 256.
  - FINISH follows the SEND_CK handshake. Total byte count is 2*MEMORY_SIZE+1.
- Undefined: no SEND_CK state and no checksum register; exactly 2*MEMORY_SIZE bytes are emitted.

Decomposition:
- Package `mem_dump_pkg` holds:
  - state enum `dump_state_t`;
  - constants WORD_W=16 and BYTE_W=8.
- One natural sub-module, `byte_tx_reg`: a single-entry output register implementing the valid/ready hold rule, loaded by the FSM and cleared on handshake.
- Address counter and FSM stay in `mem_dump`.

Test Plan:
- Memory preloaded with word i = 16'hA500+i (MEMORY_SIZE=32), start pulse, tx_ready=1 -> 64 bytes A5,00,A5,01,...,A5,1F.
  - done pulses at cycle 130 after start.
  - cpu_hold high throughout and low after done.
- Same preload, tx_ready toggling with a pseudo-random pattern (2-5 cycle stalls) -> identical 64-byte sequence; tx_data stable during every stall.
- start pulsed again at byte 10 of a dump -> ignored; sequence unchanged; exactly one done pulse.
- rst driven low at byte 20, then released, then start -> tx_valid, cpu_hold and busy go 0 asynchronously; the new dump restarts at address 0 with byte A5,00.
- MEMORY_SIZE=1, word 16'h1234 -> bytes 12,34, then done; mem_rd_en asserted exactly once at address 0.
- MEM_DUMP_CHECKSUM_EN defined, words 0x0102,0x0304 (MEMORY_SIZE=2) -> bytes 01,02,03,04,F6, then done.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared types and constants for the memory dump engine
// Optional feature macro: MEM_DUMP_CHECKSUM_EN (adds the SEND_CK state).
package mem_dump_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    READ    = 3'd2,
    WAIT    = 3'd3,
    SEND_HI = 3'd4,
    SEND_LO = 3'd5,
`ifdef MEM_DUMP_CHECKSUM_EN
    SEND_CK = 3'd7,
`endif
    FINISH  = 3'd6
  } dump_state_t;

  // Byte that brings the running sum of all emitted bytes to zero mod 256.
  function automatic logic [BYTE_W-1:0] ck_negate(input logic [BYTE_W-1:0] sum);
    return ~sum + 1'b1;
  endfunction

endpackage

// File: rtl/mem_dump_if.sv
// rtl/mem_dump_if.sv - memory read port plus outgoing byte stream of the dump engine
// master = dump engine side, slave = memory / byte sink side.
interface mem_dump_if #(
  parameter int ADDR_W = 5
) ();
  import mem_dump_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output mem_rd_en, mem_addr, tx_data, tx_valid,
    input  mem_rdata, tx_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, tx_data, tx_valid,
    output mem_rdata, tx_ready
  );

endinterface

// File: rtl/mem_dump_byte_tx_reg.sv
// rtl/mem_dump_byte_tx_reg.sv - single-entry output byte register with valid/ready hold
// A load always wins over a same-cycle handshake so back-to-back bytes need no bubble.
module byte_tx_reg
  import mem_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              ready,
  output logic [BYTE_W-1:0] data,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - holds the CPU and streams its word memory out as bytes, high byte first
// Optional feature macro: MEM_DUMP_CHECKSUM_EN appends a two's-complement checksum byte.
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int MEMORY_SIZE = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic cpu_hold,
  output logic busy,
  output logic done,
  mem_dump_if.master bus
);

  localparam int ADDR_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [BYTE_W-1:0] word_lo;
  logic              tx_load;
  logic [BYTE_W-1:0] tx_load_data;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              hs;
  logic              last_word;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [BYTE_W-1:0] sum;
`endif

  assign hs            = tx_valid & bus.tx_ready;
  assign last_word     = (addr == LAST_ADDR);
  assign busy          = (state != IDLE);
  assign bus.mem_rd_en = mem_rd_en;
  assign bus.mem_addr  = mem_addr;
  assign bus.tx_data   = tx_data;
  assign bus.tx_valid  = tx_valid;

  // The high byte goes straight from the read data into the output register,
  // so only the low byte of the word needs buffering.
  always_comb begin
    tx_load      = 1'b0;
    tx_load_data = '0;
    case (state)
      WAIT: begin
        tx_load      = 1'b1;
        tx_load_data = bus.mem_rdata[WORD_W-1:BYTE_W];
      end
      SEND_HI: begin
        if (hs) begin
          tx_load      = 1'b1;
          tx_load_data = word_lo;
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      SEND_LO: begin
        if (hs && last_word) begin
          tx_load      = 1'b1;
          tx_load_data = ck_negate(sum + tx_data);
        end
      end
`endif
      default: ;
    endcase
  end

  byte_tx_reg u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (tx_load_data),
    .ready     (bus.tx_ready),
    .data      (tx_data),
    .valid     (tx_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      word_lo   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HOLD;
            addr     <= '0;
            cpu_hold <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum      <= '0;
`endif
          end
        end
        HOLD: begin
          state     <= READ;
          mem_rd_en <= 1'b1;
          mem_addr  <= addr;
        end
        READ: state <= WAIT;
        WAIT: begin
          word_lo <= bus.mem_rdata[BYTE_W-1:0];
          state   <= SEND_HI;
        end
        SEND_HI: begin
          if (hs) begin
            state <= SEND_LO;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum   <= sum + tx_data;
`endif
          end
        end
        SEND_LO: begin
          if (hs) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            sum <= sum + tx_data;
`endif
            if (last_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
              state <= SEND_CK;
`else
              state <= FINISH;
              done  <= 1'b1;
`endif
            end else begin
              addr      <= addr + 1'b1;
              mem_addr  <= addr + 1'b1;
              mem_rd_en <= 1'b1;
              state     <= READ;
            end
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        SEND_CK: begin
          if (hs) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
`endif
        FINISH: begin
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump.sv
// tb/tb_mem_dump.sv - directed self-checking bench for mem_dump (32, 1 and 2 word memories)
// Expected streams include the checksum byte when MEM_DUMP_CHECKSUM_EN is defined.
module tb_mem_dump;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int  NB32     = 65;
  localparam int  DONE_CYC = 131;
  localparam bit  CK       = 1'b1;
`else
  localparam int  NB32     = 64;
  localparam int  DONE_CYC = 130;
  localparam bit  CK       = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start32 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic hold32, busy32, done32;
  logic hold1, busy1, done1;
  logic hold2, busy2, done2;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem32 [32];
  logic [15:0] mem1 [1];
  logic [15:0] mem2 [2];
  logic [7:0]  q [$];

  always #5 clk = ~clk;

  mem_dump_if #(.ADDR_W(5)) bus32 ();
  mem_dump_if #(.ADDR_W(1)) bus1 ();
  mem_dump_if #(.ADDR_W(1)) bus2 ();

  mem_dump #(.MEMORY_SIZE(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .cpu_hold(hold32), .busy(busy32), .done(done32), .bus(bus32)
  );
  mem_dump #(.MEMORY_SIZE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cpu_hold(hold1), .busy(busy1), .done(done1), .bus(bus1)
  );
  mem_dump #(.MEMORY_SIZE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .cpu_hold(hold2), .busy(busy2), .done(done2), .bus(bus2)
  );

  always @(posedge clk) begin
    if (bus32.mem_rd_en) bus32.mem_rdata <= mem32[bus32.mem_addr];
    if (bus1.mem_rd_en)  bus1.mem_rdata  <= mem1[0];
    if (bus2.mem_rd_en)  bus2.mem_rdata  <= mem2[bus2.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp32(input int i);
    if (i >= 64) return 8'h70;
    return (i % 2 == 0) ? 8'hA5 : 8'(i / 2);
  endfunction

  task automatic run32(input bit stalls, input int restart_at, input int rst_at, input bit chk_cyc);
    int cyc = 0, done_cnt = 0, done_cyc = 0, hold_gaps = 0, unstable = 0;
    int stall_left = 0, si = 0;
    int stall_tab [4] = '{2, 5, 3, 4};
    bit prev_stall = 0, aborted = 0, fin = 0;
    logic [7:0] prev_data = '0;
    q.delete();
    @(posedge clk); #1;
    start32 = 1'b1;
    bus32.tx_ready = 1'b1;
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start32 = 1'b0;
      if (done32) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt == 0 && !hold32) hold_gaps++;
      if (done_cyc > 0 && cyc >= done_cyc + 3) fin = 1;
      if (stalls && stall_left > 0) begin
        bus32.tx_ready = 1'b0;
        stall_left--;
      end else begin
        bus32.tx_ready = 1'b1;
      end
      if (prev_stall && (!bus32.tx_valid || bus32.tx_data !== prev_data)) unstable++;
      prev_stall = bus32.tx_valid && !bus32.tx_ready;
      prev_data  = bus32.tx_data;
      if (bus32.tx_valid && bus32.tx_ready) begin
        q.push_back(bus32.tx_data);
        if (stalls) begin
          stall_left = stall_tab[si % 4];
          si++;
        end
        if (q.size() == restart_at) start32 = 1'b1;
        if (q.size() == rst_at) begin
          #2 rst = 1'b0;
          #1;
          check("abort_tx_valid", 32'(bus32.tx_valid), 0);
          check("abort_cpu_hold", 32'(hold32), 0);
          check("abort_busy", 32'(busy32), 0);
          @(posedge clk);
          @(posedge clk); #1;
          rst = 1'b1;
          aborted = 1;
          fin = 1;
        end
      end
    end
    bus32.tx_ready = 1'b1;
    if (aborted) begin
      check("abort_no_done", 32'(done_cnt), 0);
    end else begin
      check("run_finished", 32'(fin), 1);
      check("byte_count", 32'(q.size()), 32'(NB32));
      for (int i = 0; i < q.size() && i < NB32; i++)
        check($sformatf("byte[%0d]", i), 32'(q[i]), 32'(exp32(i)));
      check("done_pulses", 32'(done_cnt), 1);
      if (chk_cyc) check("done_cycle", 32'(done_cyc), 32'(DONE_CYC));
      check("hold_during_dump", 32'(hold_gaps), 0);
      check("hold_after_done", 32'(hold32), 0);
      check("busy_after_done", 32'(busy32), 0);
      if (stalls) check("stall_stability", 32'(unstable), 0);
    end
  endtask

  task automatic run_small(input int sel);
    logic [7:0] exp_b [3];
    int nb, cyc = 0, done_cnt = 0, rd_cnt = 0, addr_bad = 0;
    bit fin = 0;
    if (sel == 1) begin
      exp_b = '{8'h12, 8'h34, 8'hBA};
      nb = CK ? 3 : 2;
    end else begin
      exp_b = '{8'h01, 8'h02, 8'h03};
      nb = CK ? 5 : 4;
    end
    q.delete();
    @(posedge clk); #1;
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    while (!fin && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start1 = 1'b0;
      start2 = 1'b0;
      if (sel == 1) begin
        if (bus1.mem_rd_en) begin
          if (bus1.mem_addr !== 1'b0) addr_bad++;
          rd_cnt++;
        end
        if (bus1.tx_valid) q.push_back(bus1.tx_data);
        if (done1) done_cnt++;
      end else begin
        if (bus2.mem_rd_en) begin
          if (bus2.mem_addr !== 1'(rd_cnt)) addr_bad++;
          rd_cnt++;
        end
        if (bus2.tx_valid) q.push_back(bus2.tx_data);
        if (done2) done_cnt++;
      end
      if (done_cnt > 0 && cyc > 8 + 4 * sel) fin = 1;
    end
    check($sformatf("m%0d_byte_count", sel), 32'(q.size()), 32'(nb));
    for (int i = 0; i < q.size() && i < nb; i++) begin
      logic [7:0] e;
      if (sel == 1) e = exp_b[i];
      else if (i < 3) e = exp_b[i];
      else if (i == 3) e = 8'h04;
      else e = 8'hF6;
      check($sformatf("m%0d_byte[%0d]", sel, i), 32'(q[i]), 32'(e));
    end
    check($sformatf("m%0d_reads", sel), 32'(rd_cnt), 32'(sel));
    check($sformatf("m%0d_read_addr", sel), 32'(addr_bad), 0);
    check($sformatf("m%0d_done_pulses", sel), 32'(done_cnt), 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem32[i] = 16'hA500 + 16'(i);
    mem1[0] = 16'h1234;
    mem2[0] = 16'h0102;
    mem2[1] = 16'h0304;
    bus32.tx_ready = 1'b1;
    bus1.tx_ready  = 1'b1;
    bus2.tx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus32.tx_valid), 0);
    check("rst_tx_data", 32'(bus32.tx_data), 0);
    check("rst_mem_rd_en", 32'(bus32.mem_rd_en), 0);
    check("rst_mem_addr", 32'(bus32.mem_addr), 0);
    check("rst_cpu_hold", 32'(hold32), 0);
    check("rst_busy", 32'(busy32), 0);
    check("rst_done", 32'(done32), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_tx_ready_no_effect", 32'(bus32.tx_valid), 0);

    run32(1'b0, 0, 0, 1'b1);
    run32(1'b1, 0, 0, 1'b0);
    run32(1'b0, 10, 0, 1'b1);
    run32(1'b0, 0, 20, 1'b0);
    run32(1'b0, 0, 0, 1'b1);
    run_small(1);
    run_small(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
